// File: rtl/sfm_acc_inv_arbiter_pkg.sv
// Shared types and helpers for the softmax accumulator / inverter arbitration slice.
package sfm_acc_inv_arbiter_pkg;

    localparam int unsigned SFM_N_REQ      = 32'd4;
    localparam int unsigned SFM_FP32_WIDTH = 32'd32;

    typedef logic [$clog2(SFM_N_REQ)-1:0] sfm_lane_id_t;

    // Only round-robin is implemented; fixed priority is reserved.
    typedef enum logic [0:0] {
        SFM_ARB_RR    = 1'b0,
        SFM_ARB_FIXED = 1'b1
    } sfm_arb_mode_e;

    function automatic int unsigned sfm_wrap_inc(input int unsigned v, input int unsigned n);
        return ((v + 32'd1) >= n) ? 32'd0 : (v + 32'd1);
    endfunction

endpackage

// File: rtl/sfm_acc_inv_arbiter_rr.sv
// N-way round-robin arbiter; a grant offered but not taken is locked until it transfers.
module sfm_acc_inv_arbiter_rr
    import sfm_acc_inv_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = SFM_N_REQ
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic                     ready_i,
    output logic                     gnt_valid_o,
    output logic [$clog2(N_REQ)-1:0] gnt_id_o
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [ID_W-1:0] ptr_r;
    logic            lock_valid_r;
    logic [ID_W-1:0] lock_id_r;
    logic            win_valid_s;
    logic [ID_W-1:0] win_id_s;

    function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] base, input int unsigned off);
        return ID_W'((32'(base) + off) % N_REQ);
    endfunction

    // Winner selection: locked lane, else first requester at or after the pointer.
    always_comb begin
        win_valid_s = 1'b0;
        win_id_s    = ptr_r;
        if (lock_valid_r) begin
            win_valid_s = req_i[lock_id_r];
            win_id_s    = lock_id_r;
        end else begin
            win_valid_s = |req_i;
            // Descending scan so the nearest lane to the pointer is assigned last and wins.
            for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
                win_id_s = req_i[rot_idx(ptr_r, 32'(i))] ? rot_idx(ptr_r, 32'(i)) : win_id_s;
            end
        end
    end

    // Pointer advance on transfer, grant lock while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            ptr_r        <= {ID_W{1'b0}};
            lock_valid_r <= 1'b0;
            lock_id_r    <= {ID_W{1'b0}};
        end else if (win_valid_s && ready_i) begin
            ptr_r        <= rot_idx(win_id_s, 32'd1);
            lock_valid_r <= 1'b0;
        end else if (win_valid_s) begin
            lock_valid_r <= 1'b1;
            lock_id_r    <= win_id_s;
        end else begin
            lock_valid_r <= 1'b0;
        end
    end

    assign gnt_valid_o = win_valid_s;
    assign gnt_id_o    = win_id_s;

endmodule

// File: rtl/sfm_acc_inv_arbiter.sv
// Shares one denominator inverter between N_REQ lanes; results are steered back in issue order
// using a tag FIFO of lane IDs. WIDTH is the float width (32 for FP32).
module sfm_acc_inv_arbiter
    import sfm_acc_inv_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH     = SFM_FP32_WIDTH,
    parameter int unsigned N_REQ     = SFM_N_REQ,
    parameter int unsigned MAX_OUTST = 32'd4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    input  logic [N_REQ-1:0]                 req_valid_i,
    input  logic [N_REQ*WIDTH-1:0]           req_den_i,
    output logic [N_REQ-1:0]                 req_ready_o,
    output logic                             inv_valid_o,
    output logic [WIDTH-1:0]                 inv_den_o,
    input  logic                             inv_ready_i,
    input  logic                             inv_valid_i,
    input  logic [WIDTH-1:0]                 inv_res_i,
    output logic                             inv_ready_o,
    output logic [N_REQ-1:0]                 res_valid_o,
    output logic [WIDTH-1:0]                 res_data_o,
    input  logic [N_REQ-1:0]                 res_ready_i,
    output logic [$clog2(MAX_OUTST+1)-1:0]   outst_o,
    output logic                             err_o
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned PTR_W = $clog2(MAX_OUTST);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    logic              flush_s;
    logic [N_REQ-1:0]  eligible_s;
    logic              gnt_valid_s;
    logic [ID_W-1:0]   gnt_id_s;
    logic              push_s;
    logic              pop_s;
    logic              drop_s;
    logic [ID_W-1:0]   head_s;
    logic [ID_W-1:0]   tag_mem_r [MAX_OUTST];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  outst_r;
    logic              err_r;

    assign flush_s = rst_i | clear_i;
    // Full check uses only the registered count: a same-cycle return never frees a slot.
    assign eligible_s = ((outst_r < CNT_W'(MAX_OUTST)) && !flush_s) ? req_valid_i : {N_REQ{1'b0}};

    sfm_acc_inv_arbiter_rr #(.N_REQ(N_REQ)) u_rr (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .req_i       (eligible_s),
        .ready_i     (inv_ready_i),
        .gnt_valid_o (gnt_valid_s),
        .gnt_id_o    (gnt_id_s)
    );

    assign inv_valid_o = gnt_valid_s;
    assign inv_den_o   = req_den_i[int'(gnt_id_s) * int'(WIDTH) +: WIDTH];
    assign push_s      = gnt_valid_s & inv_ready_i;
    assign head_s      = tag_mem_r[rd_ptr_r];
    assign res_data_o  = inv_res_i;
    assign outst_o     = outst_r;
    assign err_o       = err_r;

    // Per-lane accept follows the inverter's ready for the granted lane only.
    always_comb begin
        req_ready_o = {N_REQ{1'b0}};
        if (gnt_valid_s) begin
            req_ready_o[gnt_id_s] = inv_ready_i;
        end else begin
            req_ready_o = {N_REQ{1'b0}};
        end
    end

    // Return steering: head tag picks the lane; with no tag pending the result is dropped.
    always_comb begin
        res_valid_o = {N_REQ{1'b0}};
        inv_ready_o = 1'b0;
        pop_s       = 1'b0;
        drop_s      = 1'b0;
        if (flush_s) begin
            inv_ready_o = 1'b0;
        end else if (outst_r == {CNT_W{1'b0}}) begin
            inv_ready_o = 1'b1;
            drop_s      = inv_valid_i;
        end else begin
            res_valid_o[head_s] = inv_valid_i;
            inv_ready_o         = res_ready_i[head_s];
            pop_s               = inv_valid_i & res_ready_i[head_s];
        end
    end

    // Tag storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            tag_mem_r[wr_ptr_r] <= gnt_id_s;
        end else begin
            tag_mem_r[wr_ptr_r] <= tag_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and in-flight count.
    always_ff @(posedge clk_i) begin
        if (flush_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            outst_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= PTR_W'(sfm_wrap_inc(32'(wr_ptr_r), MAX_OUTST));
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= PTR_W'(sfm_wrap_inc(32'(rd_ptr_r), MAX_OUTST));
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   outst_r <= outst_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   outst_r <= outst_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: outst_r <= outst_r;
            endcase
        end
    end

    // Sticky orphan-result flag; survives clear_i, only reset removes it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else if (drop_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

endmodule

// File: tb/tb_sfm_acc_inv_arbiter.sv
// Directed bench for sfm_acc_inv_arbiter; the bench plays both the lanes and the inverter.
module tb_sfm_acc_inv_arbiter;

    localparam logic [31:0] D0 = 32'h3F80_0000; // 1.0
    localparam logic [31:0] D1 = 32'h4080_0000; // 4.0
    localparam logic [31:0] D2 = 32'h4000_0000; // 2.0
    localparam logic [31:0] D3 = 32'h4100_0000; // 8.0
    localparam logic [31:0] R0 = 32'h3F80_0000; // 1/1
    localparam logic [31:0] R1 = 32'h3E80_0000; // 1/4
    localparam logic [31:0] R2 = 32'h3F00_0000; // 1/2
    localparam logic [31:0] R3 = 32'h3E00_0000; // 1/8

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         clear_i;
    logic [3:0]   req_valid_i;
    logic [127:0] req_den_i;
    logic [3:0]   req_ready_o;
    logic         inv_valid_o;
    logic [31:0]  inv_den_o;
    logic         inv_ready_i;
    logic         inv_valid_i;
    logic [31:0]  inv_res_i;
    logic         inv_ready_o;
    logic [3:0]   res_valid_o;
    logic [31:0]  res_data_o;
    logic [3:0]   res_ready_i;
    logic [2:0]   outst_o;
    logic         err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    sfm_acc_inv_arbiter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .req_valid_i (req_valid_i),
        .req_den_i   (req_den_i),
        .req_ready_o (req_ready_o),
        .inv_valid_o (inv_valid_o),
        .inv_den_o   (inv_den_o),
        .inv_ready_i (inv_ready_i),
        .inv_valid_i (inv_valid_i),
        .inv_res_i   (inv_res_i),
        .inv_ready_o (inv_ready_o),
        .res_valid_o (res_valid_o),
        .res_data_o  (res_data_o),
        .res_ready_i (res_ready_i),
        .outst_o     (outst_o),
        .err_o       (err_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [31:0] dens [4];
        dens[0] = D0; dens[1] = D1; dens[2] = D2; dens[3] = D3;
        rst_i       = 1'b1;
        clear_i     = 1'b0;
        req_valid_i = 4'hF;
        req_den_i   = {D3, D2, D1, D0};
        inv_ready_i = 1'b1;
        inv_valid_i = 1'b0;
        inv_res_i   = 32'h0;
        res_ready_i = 4'hF;
        tick();
        tick();
        check_eq("rst_inv_valid", inv_valid_o, 1'b0);
        check_eq("rst_req_ready", req_ready_o, 4'h0);
        check_eq("rst_outst", outst_o, 3'd0);
        check_eq("rst_err", err_o, 1'b0);
        rst_i = 1'b0;

        // All four lanes requesting: grants rotate 0,1,2,3.
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("rr_req_ready", req_ready_o, 64'(4'b0001 << k));
            check_eq("rr_inv_den", inv_den_o, dens[k]);
            tick();
        end
        check_eq("full_outst", outst_o, 3'd4);
        check_eq("full_inv_valid", inv_valid_o, 1'b0);
        check_eq("full_req_ready", req_ready_o, 4'h0);

        // One pop while full: no issue in the same cycle, issue resumes next cycle.
        inv_valid_i = 1'b1;
        inv_res_i   = R0;
        #1;
        check_eq("pop_res_valid", res_valid_o, 4'b0001);
        check_eq("pop_res_data", res_data_o, R0);
        check_eq("pop_inv_ready", inv_ready_o, 1'b1);
        check_eq("pop_no_same_cycle_issue", inv_valid_o, 1'b0);
        tick();
        inv_valid_i = 1'b0;
        #1;
        check_eq("resume_outst", outst_o, 3'd3);
        check_eq("resume_req_ready", req_ready_o, 4'b0001);
        tick();
        req_valid_i = 4'h0;
        check_eq("refill_outst", outst_o, 3'd4);

        // Returns in issue order 1,2,3,0; lane 2 holds off for five cycles.
        inv_valid_i = 1'b1;
        inv_res_i   = R1;
        #1;
        check_eq("ret1_res_valid", res_valid_o, 4'b0010);
        check_eq("ret1_res_data", res_data_o, R1);
        tick();
        inv_res_i   = R2;
        res_ready_i = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("hol_inv_ready", inv_ready_o, 1'b0);
            check_eq("hol_res_valid", res_valid_o, 4'b0100);
            check_eq("hol_res_data", res_data_o, R2);
            tick();
        end
        check_eq("hol_outst", outst_o, 3'd3);
        res_ready_i = 4'hF;
        #1;
        check_eq("ret2_res_valid", res_valid_o, 4'b0100);
        check_eq("ret2_res_data", res_data_o, R2);
        tick();
        inv_res_i = R3;
        #1;
        check_eq("ret3_res_valid", res_valid_o, 4'b1000);
        check_eq("ret3_res_data", res_data_o, R3);
        tick();
        inv_res_i = R0;
        #1;
        check_eq("ret0_res_valid", res_valid_o, 4'b0001);
        tick();
        inv_valid_i = 1'b0;
        check_eq("drain_outst", outst_o, 3'd0);

        // Single lane-1 round trip moves the pointer to 2.
        req_valid_i = 4'b0010;
        tick();
        req_valid_i = 4'h0;
        inv_valid_i = 1'b1;
        inv_res_i   = R1;
        #1;
        check_eq("solo_res_valid", res_valid_o, 4'b0010);
        tick();
        inv_valid_i = 1'b0;

        // Grant lock: lane 1 stalled, lane 0 (ahead of 1 from pointer 2) arrives mid-stall.
        inv_ready_i = 1'b0;
        req_valid_i = 4'b0010;
        #1;
        check_eq("lock_inv_valid", inv_valid_o, 1'b1);
        check_eq("lock_den_c1", inv_den_o, D1);
        tick();
        req_valid_i = 4'b0011;
        #1;
        check_eq("lock_den_c2", inv_den_o, D1);
        check_eq("lock_req_ready_c2", req_ready_o, 4'h0);
        tick();
        #1;
        check_eq("lock_den_c3", inv_den_o, D1);
        tick();
        inv_ready_i = 1'b1;
        #1;
        check_eq("lock_accept_l1", req_ready_o, 4'b0010);
        check_eq("lock_accept_den", inv_den_o, D1);
        tick();
        req_valid_i = 4'b0001;
        #1;
        check_eq("lock_next_l0", req_ready_o, 4'b0001);
        check_eq("lock_next_den", inv_den_o, D0);
        tick();
        req_valid_i = 4'b0100;
        tick();
        req_valid_i = 4'h0;
        check_eq("pre_clear_outst", outst_o, 3'd3);

        // Flush with three in flight, then an orphan result.
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check_eq("clear_outst", outst_o, 3'd0);
        req_valid_i = 4'hF;
        inv_ready_i = 1'b0;
        #1;
        check_eq("clear_ptr_den", inv_den_o, D0);
        tick();
        req_valid_i = 4'h0;
        inv_ready_i = 1'b1;
        tick();
        inv_valid_i = 1'b1;
        inv_res_i   = R3;
        #1;
        check_eq("orphan_inv_ready", inv_ready_o, 1'b1);
        check_eq("orphan_res_valid", res_valid_o, 4'h0);
        tick();
        inv_valid_i = 1'b0;
        check_eq("orphan_err", err_o, 1'b1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check_eq("clear_keeps_err", err_o, 1'b1);

        // Reset mid-burst.
        req_valid_i = 4'hF;
        tick();
        tick();
        check_eq("burst_outst", outst_o, 3'd2);
        rst_i = 1'b1;
        #1;
        check_eq("mid_rst_inv_valid", inv_valid_o, 1'b0);
        check_eq("mid_rst_req_ready", req_ready_o, 4'h0);
        tick();
        rst_i = 1'b0;
        #1;
        check_eq("post_rst_outst", outst_o, 3'd0);
        check_eq("post_rst_err", err_o, 1'b0);
        check_eq("post_rst_first_l0", req_ready_o, 4'b0001);
        tick();
        req_valid_i = 4'h0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
